// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller.
// Optional BNE support is enabled by defining MULTICYCLE_CTRL_BNE_EN.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_ERROR  = 4'd12,
      S_BNE    = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   typedef struct packed {
      logic       iord;
      logic       irwrite;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       branch;
      logic       branch_ne;
      logic       pcwrite;
      logic       regwrite;
      logic       regdst;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
   } ctrl_t;

   // FETCH's irwrite/pcwrite depend on mem_ready and are gated in the top.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.memread = 1'b1;
            c.alusrcb = SRCB_FOUR;
         end
         S_DECODE: c.alusrcb = SRCB_IMMSH;
         S_MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
         end
         S_MEMRD: begin
            c.iord    = 1'b1;
            c.memread = 1'b1;
         end
         S_MEMWB: begin
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
         end
         S_MEMWR: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         S_EXEC: begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
         end
         S_BRANCH: begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_SUB;
            c.pcsrc   = PCSRC_ALUOUT;
            c.branch  = 1'b1;
         end
         S_ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
         end
         S_ADDIWB: c.regwrite = 1'b1;
         S_JUMP: begin
            c.pcsrc   = PCSRC_JUMP;
            c.pcwrite = 1'b1;
         end
`ifdef MULTICYCLE_CTRL_BNE_EN
         S_BNE: begin
            c.alusrca   = 1'b1;
            c.aluop     = ALUOP_SUB;
            c.pcsrc     = PCSRC_ALUOUT;
            c.branch    = 1'b1;
            c.branch_ne = 1'b1;
         end
`endif
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts memory-wait cycles and flags a timeout on the last allowed one.
// MAX=0 disables the timeout.
module mc_wait_timer #(
   parameter int unsigned MAX = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic waiting,
   input  logic mem_ready,
   input  logic restart,
   output logic expire
);

   localparam int unsigned W = (MAX < 2) ? 1 : $clog2(MAX);
   localparam logic [W-1:0] LAST = W'((MAX == 0) ? 0 : MAX - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (restart)
         cnt <= '0;
      else if (waiting && !mem_ready && cnt != LAST)
         cnt <= cnt + W'(1);
   end

   // Fires on the MAX-th stalled cycle; a ready in that cycle still wins.
   assign expire = (MAX != 0) && waiting && !mem_ready && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with memory-wait timeout and retire counter.
// Define MULTICYCLE_CTRL_BNE_EN to decode op 000101 into the BNE state.
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int unsigned OP_W         = 6,
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OP_W-1:0]  op,
   input  logic             mem_ready,
   output logic             iord,
   output logic             irwrite,
   output logic             memread,
   output logic             memwrite,
   output logic             memtoreg,
   output logic             branch,
   output logic             branch_ne,
   output logic             pcwrite,
   output logic             regwrite,
   output logic             regdst,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       aluop,
   output logic [1:0]       pcsrc,
   output logic [3:0]       state_o,
   output logic             illegal_op,
   output logic             timeout,
   output logic [CNT_W-1:0] instret
);

   state_t state, nxt;
   ctrl_t  ctrl_q;
   logic   waiting, expire, illegal_nxt, retire;
   logic   is_rtype, is_lw, is_sw, is_beq, is_addi, is_j, is_bne;

   assign is_rtype = (op == OP_W'(OP_RTYPE));
   assign is_lw    = (op == OP_W'(OP_LW));
   assign is_sw    = (op == OP_W'(OP_SW));
   assign is_beq   = (op == OP_W'(OP_BEQ));
   assign is_addi  = (op == OP_W'(OP_ADDI));
   assign is_j     = (op == OP_W'(OP_J));
   assign is_bne   = (op == OP_W'(OP_BNE));

   assign waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

   always_comb begin
      nxt         = state;
      illegal_nxt = 1'b0;
      case (state)
         S_FETCH:
            if (mem_ready)   nxt = S_DECODE;
            else if (expire) nxt = S_ERROR;
         S_DECODE:
            if (is_rtype)            nxt = S_EXEC;
            else if (is_lw || is_sw) nxt = S_MEMADR;
            else if (is_beq)         nxt = S_BRANCH;
            else if (is_addi)        nxt = S_ADDIEX;
            else if (is_j)           nxt = S_JUMP;
`ifdef MULTICYCLE_CTRL_BNE_EN
            else if (is_bne)         nxt = S_BNE;
`endif
            else begin
               nxt         = S_ERROR;
               illegal_nxt = 1'b1;
            end
         S_MEMADR: nxt = is_lw ? S_MEMRD : S_MEMWR;
         S_MEMRD:
            if (mem_ready)   nxt = S_MEMWB;
            else if (expire) nxt = S_ERROR;
         S_MEMWR:
            if (mem_ready)   nxt = S_FETCH;
            else if (expire) nxt = S_ERROR;
         S_MEMWB:  nxt = S_FETCH;
         S_EXEC:   nxt = S_ALUWB;
         S_ALUWB:  nxt = S_FETCH;
         S_BRANCH: nxt = S_FETCH;
         S_ADDIEX: nxt = S_ADDIWB;
         S_ADDIWB: nxt = S_FETCH;
         S_JUMP:   nxt = S_FETCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
         S_BNE:    nxt = S_FETCH;
`endif
         S_ERROR:  nxt = S_ERROR;
         default:  nxt = S_ERROR;
      endcase
   end

   assign retire = (nxt == S_FETCH) &&
                   (state inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_BNE, S_ADDIWB, S_JUMP});

   mc_wait_timer #(.MAX(MEM_WAIT_MAX)) u_wait (
      .clk       (clk),
      .rst_n     (rst_n),
      .waiting   (waiting),
      .mem_ready (mem_ready),
      .restart   (nxt != state),
      .expire    (expire)
   );

   // Controls are registered from the next state so they line up with state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_FETCH;
         ctrl_q     <= state_ctrl(S_FETCH);
         instret    <= '0;
         illegal_op <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state  <= nxt;
         ctrl_q <= state_ctrl(nxt);
         if (retire)      instret    <= instret + CNT_W'(1);
         if (illegal_nxt) illegal_op <= 1'b1;
         if (expire)      timeout    <= 1'b1;
      end
   end

   assign iord      = ctrl_q.iord;
   assign irwrite   = ctrl_q.irwrite | ((state == S_FETCH) & mem_ready);
   assign memread   = ctrl_q.memread;
   assign memwrite  = ctrl_q.memwrite;
   assign memtoreg  = ctrl_q.memtoreg;
   assign branch    = ctrl_q.branch;
   assign branch_ne = ctrl_q.branch_ne;
   assign pcwrite   = ctrl_q.pcwrite | ((state == S_FETCH) & mem_ready);
   assign regwrite  = ctrl_q.regwrite;
   assign regdst    = ctrl_q.regdst;
   assign alusrca   = ctrl_q.alusrca;
   assign alusrcb   = ctrl_q.alusrcb;
   assign aluop     = ctrl_q.aluop;
   assign pcsrc     = ctrl_q.pcsrc;
   assign state_o   = state;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter OP_W, 6: opcode width; opcode values below are given in the low 6 bits, upper bits must be 0.
REQ-002 Parameter MEM_WAIT_MAX, 15: maximum wait cycles with mem_ready low before timeout; 0 disables the timeout.
REQ-003 Parameter CNT_W, 32: width of the retired-instruction counter.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port op, input, OP_W: instruction opcode, sampled in DECODE and MEMADR.
REQ-007 Port mem_ready, input, 1: memory completes the current access this cycle.
REQ-008 Ports iord, irwrite, memread, memwrite, memtoreg, branch, branch_ne, pcwrite, regwrite, regdst, alusrca, output, 1 each: datapath controls.
REQ-009 Ports alusrcb, aluop, pcsrc, output, 2 each: datapath selects.
REQ-010 Port state_o, output, 4: current state encoding.
REQ-011 Ports illegal_op and timeout, output, 1 each: sticky error flags.
REQ-012 Port instret, output, CNT_W: count of retired instructions.

Function
REQ-013 States and encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, ERROR 12, BNE 13.
REQ-014 Outputs SHALL be 0 except as listed per state in REQ-015..REQ-026.
REQ-015 FETCH: memread=1, alusrcb=01; irwrite and pcwrite equal mem_ready; on mem_ready go DECODE, otherwise hold.
REQ-016 DECODE: alusrcb=11. Next state by op: 000000 EXEC; 100011 or 101011 MEMADR; 000100 BRANCH; 001000 ADDIEX; 000010 JUMP; 000101 BNE (macro only); anything else ERROR with illegal_op set.
REQ-017 MEMADR: alusrca=1, alusrcb=10. op 100011 goes to MEMRD; otherwise goes to MEMWR.
REQ-018 MEMRD: iord=1, memread=1; hold until mem_ready, then go MEMWB.
REQ-019 MEMWB: memtoreg=1, regwrite=1; then go FETCH.
REQ-020 MEMWR: iord=1, memwrite=1; hold until mem_ready, then go FETCH.
REQ-021 EXEC: alusrca=1, aluop=10; then go ALUWB. ALUWB: regdst=1, regwrite=1; then go FETCH.
REQ-022 BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1; then go FETCH.
REQ-023 ADDIEX: alusrca=1, alusrcb=10; then go ADDIWB. ADDIWB: regwrite=1; then go FETCH.
REQ-024 JUMP: pcsrc=10, pcwrite=1; then go FETCH.
REQ-025 ERROR: all controls 0; held until reset.
REQ-026 Wait counter:
- counts cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0;
- clears on every state change;
- when it reaches MEM_WAIT_MAX with mem_ready still 0, the next state is ERROR and timeout is set;
- if mem_ready=1 in that same cycle, the access completes normally.
REQ-027 instret SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, BNE, ADDIWB or JUMP, and wrap modulo 2^CNT_W.

Reset
REQ-028 When rst_n=0, the block SHALL asynchronously set state=FETCH and clear the wait counter, instret, illegal_op and timeout.
REQ-029 Reset SHALL abort any operation in progress, including a pending memory wait, with no further output effects.
REQ-030 In the first cycle after reset release, outputs SHALL be the FETCH values.

Configuration
REQ-031 With macro MULTICYCLE_CTRL_BNE_EN defined:
- op 000101 goes to BNE;
- BNE drives the BRANCH outputs plus branch_ne=1, then goes to FETCH.
REQ-032 Without the macro, branch_ne SHALL be tied 0, state 13 SHALL be unreachable, and op 000101 SHALL be illegal.

Structure
REQ-033 A shared package mc_pkg SHALL hold the state enum, the opcode constants, and the aluop/pcsrc/alusrcb encodings.
REQ-034 One sub-module, mc_wait_timer, SHALL implement the wait counter and timeout compare.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- LW (op 100011), mem_ready held 0 for 3 cycles in MEMRD: states 0,1,2,3,3,3,3,4,0; instret +1.
- R-type (op 000000), mem_ready=1: states 0,1,6,7,0; regdst=1 and regwrite=1 only in ALUWB.
- op 111111: ERROR reached in the cycle after DECODE, illegal_op=1, all controls 0 until rst_n pulse; after rst_n, state 0 and flags 0.
- MEM_WAIT_MAX=4, mem_ready=0 in FETCH: ERROR after 4 wait cycles, timeout=1; repeat with mem_ready=1 on the 4th cycle: DECODE, timeout=0.
- op 000101: with the macro, states 0,1,13,0 with branch_ne=1 in state 13; without it, ERROR with illegal_op=1.
- CNT_W=4, 17 JUMP instructions: instret=1 (wrapped); rst_n asserted mid-MEMWR: state 0, memwrite drops immediately.
